// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to instruction
// memory, and buffers returned {pc, inst} pairs in a small FIFO for decode. Handles decode
// stall and branch redirect, including dropping a response that is already in flight.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDiscard
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]       pc_mem_q   [DEPTH];
    logic [31:0]       pc_mem_d   [DEPTH];
    logic [31:0]       inst_mem_q [DEPTH];
    logic [31:0]       inst_mem_d [DEPTH];

    logic        handshake;
    logic        push;
    logic        pop;
    logic        head_valid;
    logic        unused_tgt;

    // Low target bits are forced to zero, so they never reach any logic.
    assign unused_tgt = ^branch_target_i[1:0];

    assign head_valid = (count_q != '0) && !rst;
    assign handshake  = mem_req_o && mem_gnt_i;
    // A response that lands in the same cycle as a redirect belongs to the old stream.
    assign push       = (state_q == StWait) && mem_rvalid_i && !branch_flag_i;
    assign pop        = inst_valid_o && !stall_i;

    // Memory request and decode-facing outputs.
    always_comb begin
        mem_req_o    = (state_q == StIdle) && (count_q < CountFull) && !branch_flag_i && !rst;
        mem_addr_o   = rst ? RESET_PC : fetch_pc_q;
        inst_valid_o = head_valid && !branch_flag_i;
        pc_o         = 32'h0;
        inst_o       = 32'h0;
        if (head_valid) begin
            pc_o   = pc_mem_q[rd_ptr_q];
            inst_o = inst_mem_q[rd_ptr_q];
        end
    end

    // Next-state: request FSM, PC, FIFO bookkeeping; redirect overrides push/pop.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;

        case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d    = StWait;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            StWait: begin
                if (branch_flag_i) begin
                    state_d = mem_rvalid_i ? StIdle : StDiscard;
                end else if (mem_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            StDiscard: begin
                if (mem_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (push) begin
            pc_mem_d[wr_ptr_q]   = req_pc_q;
            inst_mem_d[wr_ptr_q] = mem_rdata_i;
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end

        if (branch_flag_i) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = {branch_target_i[31:2], 2'b00};
        end
    end

    // Control state with synchronous reset; an outstanding request is simply forgotten.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only visible through count, so no reset is needed.
    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch stream.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory slave state.
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    int          mem_lat = 1;
    bit          gnt_rand = 1'b0;

    // Stream model: entries held, outstanding request, whether it will be kept,
    // next expected head pc and next expected request address.
    int          m_count = 0;
    bit          m_out = 1'b0;
    bit          m_keep = 1'b0;
    logic [31:0] m_exp_pc = RESET_PC;
    logic [31:0] m_req_pc = RESET_PC;

    inst_fetch #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o)
    );

    always #5 clk = ~clk;

    task automatic settle();
        @(negedge clk);
    endtask

    // Update the model and memory slave across one rising edge.
    task automatic advance();
        bit          hs;
        bit          rv;
        bit          br;
        bit          pop;
        bit          push;
        logic [31:0] tgt;
        logic [31:0] addr;
        hs   = mem_req_o && mem_gnt_i;
        rv   = mem_rvalid_i;
        br   = branch_flag_i;
        tgt  = {branch_target_i[31:2], 2'b00};
        addr = mem_addr_o;
        if (rst) begin
            m_count  = 0;
            m_out    = 1'b0;
            m_keep   = 1'b0;
            m_req_pc = RESET_PC;
            m_exp_pc = RESET_PC;
        end else begin
            pop  = (m_count != 0) && !br && !stall_i;
            push = rv && m_out && m_keep && !br;
            if (rv) m_out = 1'b0;
            if (hs) begin
                m_out    = 1'b1;
                m_keep   = 1'b1;
                m_req_pc = m_req_pc + 32'd4;
            end
            if (pop) begin
                m_count  = m_count - 1;
                m_exp_pc = m_exp_pc + 32'd4;
            end
            if (push) m_count = m_count + 1;
            if (br) begin
                m_count  = 0;
                m_keep   = 1'b0;
                m_req_pc = tgt;
                m_exp_pc = tgt;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (rv) pend = 1'b0;
            if (hs) begin
                pend      = 1'b1;
                pend_addr = addr;
                pend_cnt  = mem_lat - 1;
            end else if (pend && pend_cnt > 0) begin
                pend_cnt = pend_cnt - 1;
            end
        end
        mem_rvalid_i = pend && (pend_cnt == 0);
        mem_rdata_i  = mem_rvalid_i ? (pend_addr ^ KEY) : $urandom;
        mem_gnt_i    = gnt_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        gnt_rand      = 1'b0;
        mem_lat       = 1;
        repeat (2) begin
            settle();
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        settle();
        advance();
        settle();
        n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
        n_tests++; if (mem_addr_o !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", mem_addr_o, RESET_PC); end
        n_tests++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
        n_tests++; if (pc_o !== 32'h0 || inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_head: got %h/%h want 0/0", pc_o, inst_o); end
        advance();
        rst = 1'b0;
        settle();
        n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== RESET_PC) begin n_fail++; $display("FAIL first_req: got %b@%h want 1@%h", mem_req_o, mem_addr_o, RESET_PC); end
        advance();
    endtask

    task automatic test_stream();
        logic [31:0] reqs[$];
        int          req_cyc[$];
        logic [31:0] opc[$];
        logic [31:0] oinst[$];
        do_reset();
        for (int k = 0; k < 24; k++) begin
            settle();
            if (mem_req_o && mem_gnt_i) begin
                reqs.push_back(mem_addr_o);
                req_cyc.push_back(k);
            end
            if (inst_valid_o) begin
                opc.push_back(pc_o);
                oinst.push_back(inst_o);
            end
            advance();
        end
        n_tests++; if (reqs.size() != 12) begin n_fail++; $display("FAIL stream_nreq: got %0d want 12", reqs.size()); end
        n_tests++; if (opc.size() != 11) begin n_fail++; $display("FAIL stream_nout: got %0d want 11", opc.size()); end
        for (int i = 0; i < reqs.size(); i++) begin
            n_tests++;
            if (reqs[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_req[%0d]: got %h want %h", i, reqs[i], 32'(4 * i)); end
            if (i > 0) begin
                n_tests++;
                if (req_cyc[i] - req_cyc[i-1] != 2) begin n_fail++; $display("FAIL stream_gap[%0d]: got %0d want 2", i, req_cyc[i] - req_cyc[i-1]); end
            end
        end
        for (int i = 0; i < opc.size(); i++) begin
            n_tests++;
            if (opc[i] !== 32'(4 * i) || oinst[i] !== (32'(4 * i) ^ KEY)) begin
                n_fail++; $display("FAIL stream_out[%0d]: got %h/%h want %h/%h", i, opc[i], oinst[i], 32'(4 * i), 32'(4 * i) ^ KEY);
            end
        end
    endtask

    task automatic test_stall_full();
        do_reset();
        stall_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            settle();
            if (k >= 4) begin
                n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL full_req[%0d]: got %b want 0", k, mem_req_o); end
                n_tests++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL full_head[%0d]: got %b/%h want 1/0", k, inst_valid_o, pc_o); end
            end
            advance();
        end
        stall_i = 1'b0;
        settle();
        n_tests++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL release_pop0: got %b/%h want 1/0", inst_valid_o, pc_o); end
        n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL release_req0: got %b want 0", mem_req_o); end
        advance();
        settle();
        n_tests++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h4) begin n_fail++; $display("FAIL release_pop1: got %b/%h want 1/4", inst_valid_o, pc_o); end
        n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin n_fail++; $display("FAIL release_req1: got %b@%h want 1@8", mem_req_o, mem_addr_o); end
        advance();
    endtask

    task automatic test_redirect_wait();
        do_reset();
        branch_target_i = 32'h0000_0103;
        for (int k = 0; k < 13; k++) begin
            stall_i       = (k >= 3 && k <= 5);
            branch_flag_i = (k == 5);
            mem_lat       = (k == 4) ? 3 : 1;
            settle();
            n_tests++; if (inst_valid_o === 1'b1 && pc_o === 32'h8) begin n_fail++; $display("FAIL rw_stale[%0d]: got pc %h, want no pc 8", k, pc_o); end
            if (k == 4) begin
                n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin n_fail++; $display("FAIL rw_req8: got %b@%h want 1@8", mem_req_o, mem_addr_o); end
            end
            if (k == 5) begin
                n_tests++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_gate: got %b want 0", inst_valid_o); end
            end
            if (k == 6 || k == 7) begin
                n_tests++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_discard[%0d]: got req %b valid %b want 0 0", k, mem_req_o, inst_valid_o); end
            end
            if (k == 8) begin
                n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL rw_newreq: got %b@%h want 1@100", mem_req_o, mem_addr_o); end
            end
            if (k == 10) begin
                n_tests++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== (32'h100 ^ KEY)) begin
                    n_fail++; $display("FAIL rw_first: got %b %h/%h want 1 100/%h", inst_valid_o, pc_o, inst_o, 32'h100 ^ KEY);
                end
            end
            advance();
        end
        branch_flag_i = 1'b0;
        stall_i       = 1'b0;
    endtask

    task automatic test_redirect_pop_rvalid();
        do_reset();
        branch_target_i = 32'h0000_0200;
        for (int k = 0; k < 7; k++) begin
            stall_i       = (k == 2);
            branch_flag_i = (k == 3);
            settle();
            if (k == 3) begin
                n_tests++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rp_gate: got valid %b req %b want 0 0", inst_valid_o, mem_req_o); end
            end
            if (k == 4) begin
                n_tests++; if (inst_valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin n_fail++; $display("FAIL rp_empty: got %b %h/%h want 0 0/0", inst_valid_o, pc_o, inst_o); end
                n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin n_fail++; $display("FAIL rp_idle: got %b@%h want 1@200", mem_req_o, mem_addr_o); end
            end
            if (k == 6) begin
                n_tests++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h200 || inst_o !== (32'h200 ^ KEY)) begin n_fail++; $display("FAIL rp_first: got %b %h/%h want 1 200/%h", inst_valid_o, pc_o, inst_o, 32'h200 ^ KEY); end
            end
            advance();
        end
        branch_flag_i = 1'b0;
        stall_i       = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        branch_target_i = 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) begin
            branch_flag_i = (k == 0);
            settle();
            if (k == 0) begin
                n_tests++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL wrap_gate: got %b want 0", mem_req_o); end
            end
            if (k == 1) begin
                n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0: got %b@%h want 1@fffffffc", mem_req_o, mem_addr_o); end
            end
            if (k == 3) begin
                n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_req1: got %b@%h want 1@0", mem_req_o, mem_addr_o); end
                n_tests++; if (inst_valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || inst_o !== 32'h5A5A_FFFC) begin
                    n_fail++; $display("FAIL wrap_out: got %b %h/%h want 1 fffffffc/5a5afffc", inst_valid_o, pc_o, inst_o);
                end
            end
            advance();
        end
        branch_flag_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            rst     = (k == 4);
            stall_i = (k < 5);
            mem_lat = (k == 2) ? 4 : 1;
            settle();
            if (k == 3) begin
                n_tests++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rm_pre: got %b %h req %b want 1 0 req 0", inst_valid_o, pc_o, mem_req_o); end
            end
            if (k == 4) begin
                n_tests++; if (inst_valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin n_fail++; $display("FAIL rm_out: got %b %h/%h want 0 0/0", inst_valid_o, pc_o, inst_o); end
                n_tests++; if (mem_req_o !== 1'b0 || mem_addr_o !== RESET_PC) begin n_fail++; $display("FAIL rm_mem: got %b@%h want 0@%h", mem_req_o, mem_addr_o, RESET_PC); end
            end
            if (k == 5) begin
                n_tests++; if (mem_req_o !== 1'b1 || mem_addr_o !== RESET_PC || inst_valid_o !== 1'b0) begin
                    n_fail++; $display("FAIL rm_after: got %b@%h valid %b want 1@%h valid 0", mem_req_o, mem_addr_o, inst_valid_o, RESET_PC);
                end
            end
            advance();
        end
        rst     = 1'b0;
        stall_i = 1'b0;
    endtask

    task automatic test_random();
        bit          exp_req;
        bit          exp_valid;
        bit          has_head;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        do_reset();
        gnt_rand = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            rst             = ($urandom_range(0, 199) == 0);
            stall_i         = ($urandom_range(0, 9) < 3);
            branch_flag_i   = ($urandom_range(0, 19) == 0);
            branch_target_i = $urandom;
            mem_lat         = $urandom_range(1, 3);
            settle();
            exp_req   = !rst && !m_out && (m_count < DEPTH) && !branch_flag_i;
            has_head  = !rst && (m_count != 0);
            exp_valid = has_head && !branch_flag_i;
            exp_pc    = has_head ? m_exp_pc : 32'h0;
            exp_inst  = has_head ? (m_exp_pc ^ KEY) : 32'h0;
            n_tests++; if (mem_req_o !== exp_req) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", k, mem_req_o, exp_req); end
            if (exp_req) begin
                n_tests++; if (mem_addr_o !== m_req_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", k, mem_addr_o, m_req_pc); end
            end
            n_tests++; if (inst_valid_o !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", k, inst_valid_o, exp_valid); end
            n_tests++; if (pc_o !== exp_pc || inst_o !== exp_inst) begin n_fail++; $display("FAIL rnd_head@%0d: got %h/%h want %h/%h", k, pc_o, inst_o, exp_pc, exp_inst); end
            advance();
        end
        rst           = 1'b0;
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        gnt_rand      = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        mem_gnt_i       = 1'b1;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = 32'h0;
        test_reset();
        test_stream();
        test_stall_full();
        test_redirect_wait();
        test_redirect_pop_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
